// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the fetch/decode stage:
//                opcode prefixes, destination codes, source codes, ALU
//                function codes and the decoded control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction loaded into IR on reset: move x0 <- x0, which decodes to NOP
  localparam logic [7:0] NOP_INSTR = 8'h80;

  // Opcode prefixes, MSB-aligned
  localparam logic       OP_LDI_PFX = 1'b0;     // 0ddd_iiii
  localparam logic [1:0] OP_MOV_PFX = 2'b10;    // 10dd_dsss
  localparam logic [2:0] OP_ALU_PFX = 3'b110;   // 110x_yfff
  localparam logic [3:0] OP_JMP_PFX = 4'b1110;  // 1110_aaaa
  localparam logic [3:0] OP_JNZ_PFX = 4'b1111;  // 1111_aaaa

  // Destination / source register codes (bit index into reg_en)
  localparam logic [2:0] DST_X0   = 3'd0;
  localparam logic [2:0] DST_X1   = 3'd1;
  localparam logic [2:0] DST_Y0   = 3'd2;
  localparam logic [2:0] DST_Y1   = 3'd3;
  localparam logic [2:0] DST_OREG = 3'd4;
  localparam logic [2:0] DST_M    = 3'd5;
  localparam logic [2:0] DST_I    = 3'd6;
  localparam logic [2:0] DST_DM   = 3'd7;

  // Source select value that routes the immediate field onto the bus
  localparam logic [3:0] SRC_IMM = 4'd8;

  // ALU function codes carried in IR[2:0]
  localparam logic [2:0] ALU_FN_0 = 3'd0;
  localparam logic [2:0] ALU_FN_1 = 3'd1;
  localparam logic [2:0] ALU_FN_2 = 3'd2;
  localparam logic [2:0] ALU_FN_3 = 3'd3;
  localparam logic [2:0] ALU_FN_4 = 3'd4;
  localparam logic [2:0] ALU_FN_5 = 3'd5;
  localparam logic [2:0] ALU_FN_6 = 3'd6;
  localparam logic [2:0] ALU_FN_7 = 3'd7;

  // Full set of decoded controls for one instruction
  typedef struct packed {
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic       alu_x_sel;
    logic       alu_y_sel;
    logic [2:0] alu_func;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
  } ctrl_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder
//  Description : Registers the fetched instruction into IR, decodes it into
//                datapath and jump controls, and squashes the single
//                wrong-path instruction that follows a taken jump.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder
  import cpu_pkg::*;
#(
  parameter logic [7:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       dont_jmp,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic [7:0] reg_en,
  output logic [3:0] src_sel,
  output logic [3:0] imm,
  output logic       alu_en,
  output logic       alu_x_sel,
  output logic       alu_y_sel,
  output logic [2:0] alu_func,
  output logic [7:0] from_ID
);

  logic [7:0] ir_q;
  logic       flush_q;
  logic       flush_d;
  logic       taken;
  ctrl_t      dec_raw;
  ctrl_t      dec_out;

  // IR and flush registers; reset wins over a pending flush
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir_q    <= NOP_INSTR;
      flush_q <= 1'b0;
    end else begin
      ir_q    <= pm_data;
      flush_q <= flush_d;
    end
  end

  // Ungated decode of the instruction currently held in IR
  always_comb begin
    dec_raw     = '0;
    dec_raw.imm = ir_q[3:0];
    if (ir_q[7] == OP_LDI_PFX) begin
      dec_raw.reg_en  = 8'd1 << ir_q[6:4];
      dec_raw.src_sel = SRC_IMM;
    end else if (ir_q[7:6] == OP_MOV_PFX) begin
      dec_raw.src_sel = {1'b0, ir_q[2:0]};
      // A move onto itself is the architectural NOP: no register load
      if (ir_q[5:3] != ir_q[2:0]) begin
        dec_raw.reg_en = 8'd1 << ir_q[5:3];
      end
    end else if (ir_q[7:5] == OP_ALU_PFX) begin
      dec_raw.alu_en    = 1'b1;
      dec_raw.alu_x_sel = ir_q[4];
      dec_raw.alu_y_sel = ir_q[3];
      dec_raw.alu_func  = ir_q[2:0];
    end else if (ir_q[7:4] == OP_JMP_PFX) begin
      dec_raw.jmp      = 1'b1;
      dec_raw.jmp_addr = ir_q[3:0];
    end else begin
      dec_raw.jmp_nz   = 1'b1;
      dec_raw.jmp_addr = ir_q[3:0];
    end
  end

  // Taken-jump detection; a jump sitting in the flush slot is itself
  // squashed, so it must not schedule another bubble
  always_comb begin
    taken   = dec_raw.jmp | (dec_raw.jmp_nz & ~dont_jmp);
    flush_d = taken & ~flush_q;
  end

  // Output gating: the wrong-path instruction behind a taken jump drives nothing
  always_comb begin
    dec_out = flush_q ? '0 : dec_raw;
  end

  assign jmp       = dec_out.jmp;
  assign jmp_nz    = dec_out.jmp_nz;
  assign jmp_addr  = dec_out.jmp_addr;
  assign reg_en    = dec_out.reg_en;
  assign src_sel   = dec_out.src_sel;
  assign imm       = dec_out.imm;
  assign alu_en    = dec_out.alu_en;
  assign alu_x_sel = dec_out.alu_x_sel;
  assign alu_y_sel = dec_out.alu_y_sel;
  assign alu_func  = dec_out.alu_func;
  assign from_ID   = ir_q;

endmodule : instruction_decoder
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decoder
//  Description : Self-checking bench for instruction_decoder: directed
//                program snippets followed by random instruction streams,
//                compared against a behavioural pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic       clk;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       dont_jmp;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic [3:0] imm;
  logic       alu_en;
  logic       alu_x_sel;
  logic       alu_y_sel;
  logic [2:0] alu_func;
  logic [7:0] from_ID;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: what the IR holds and whether it is a bubble
  int  m_ir;
  bit  m_flush;
  bit  m_valid = 0;

  instruction_decoder #(.NOP_INSTR(8'h80)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .pm_data    (pm_data),
    .dont_jmp   (dont_jmp),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .reg_en     (reg_en),
    .src_sel    (src_sel),
    .imm        (imm),
    .alu_en     (alu_en),
    .alu_x_sel  (alu_x_sel),
    .alu_y_sel  (alu_y_sel),
    .alu_func   (alu_func),
    .from_ID    (from_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control fields for one instruction byte, from the ISA rules
  task automatic model_decode(input int ins,
                              output int e_reg_en, output int e_src, output int e_imm,
                              output int e_alu, output int e_x, output int e_y, output int e_fn,
                              output int e_jmp, output int e_jnz, output int e_addr);
    int d, s;
    e_reg_en = 0; e_src = 0; e_alu = 0; e_x = 0; e_y = 0; e_fn = 0;
    e_jmp = 0; e_jnz = 0; e_addr = 0;
    e_imm = ins % 16;
    if (ins < 128) begin
      e_reg_en = 2 ** (ins / 16);
      e_src    = 8;
    end else if (ins < 192) begin
      d = (ins / 8) % 8;
      s = ins % 8;
      e_src = s;
      if (d != s) e_reg_en = 2 ** d;
    end else if (ins < 224) begin
      e_alu = 1;
      e_x   = (ins / 16) % 2;
      e_y   = (ins / 8) % 2;
      e_fn  = ins % 8;
    end else if (ins < 240) begin
      e_jmp  = 1;
      e_addr = ins % 16;
    end else begin
      e_jnz  = 1;
      e_addr = ins % 16;
    end
  endtask

  task automatic check_outputs();
    int er, es, ei, ea, ex, ey, ef, ej, ejn, ead;
    model_decode(m_ir, er, es, ei, ea, ex, ey, ef, ej, ejn, ead);
    if (m_flush) begin
      er = 0; es = 0; ei = 0; ea = 0; ex = 0; ey = 0; ef = 0; ej = 0; ejn = 0; ead = 0;
    end
    check("from_ID",  32'(from_ID),  32'(m_ir));
    check("reg_en",   32'(reg_en),   32'(er));
    check("src_sel",  32'(src_sel),  32'(es));
    check("imm",      32'(imm),      32'(ei));
    check("alu",      {26'd0, alu_en, alu_x_sel, alu_y_sel, alu_func}, 32'((ea * 32) + (ex * 16) + (ey * 8) + ef));
    check("jump",     {26'd0, jmp, jmp_nz, jmp_addr}, 32'((ej * 32) + (ejn * 16) + ead));
  endtask

  // One clock cycle: check what is on the outputs now, then apply inputs
  // for the next edge and advance the model across it
  task automatic cyc(input int pm, input bit dj, input bit rst);
    bit taken;
    if (m_valid) check_outputs();
    pm_data    = 8'(pm);
    dont_jmp   = dj;
    sync_reset = rst;
    @(posedge clk);
    if (rst) begin
      m_ir    = 8'h80;
      m_flush = 0;
      m_valid = 1;
    end else begin
      taken   = !m_flush && ((m_ir >= 224 && m_ir < 240) || (m_ir >= 240 && !dj));
      m_flush = taken;
      m_ir    = pm;
    end
    #1;
  endtask

  initial begin
    pm_data    = 8'h00;
    dont_jmp   = 1'b0;
    sync_reset = 1'b1;
    #2;
    // Reset held two cycles with a jump on the bus
    cyc(8'hE5, 0, 1);
    cyc(8'hE5, 0, 1);
    // Reset state checked explicitly as well as through the model
    check("rst_from_ID", 32'(from_ID), 32'h80);
    check("rst_ctrl", {reg_en, src_sel, jmp, jmp_nz, alu_en}, 32'h0);
    // Load immediate, move, move-to-self NOP, ALU
    cyc(8'h37, 0, 0);
    cyc(8'h8B, 0, 0);
    cyc(8'h9B, 0, 0);
    cyc(8'hD5, 0, 0);
    // Unconditional jump, squashed slot, executing target
    cyc(8'hE5, 0, 0);
    cyc(8'h21, 0, 0);
    cyc(8'h21, 0, 0);
    cyc(8'h12, 0, 0);
    // Conditional taken (dont_jmp low while F3 sits in IR)
    cyc(8'hF3, 0, 0);
    cyc(8'h21, 0, 0);
    cyc(8'h21, 0, 0);
    cyc(8'h12, 0, 0);
    // Conditional not taken
    cyc(8'hF3, 0, 0);
    cyc(8'h21, 1, 0);
    cyc(8'h45, 1, 0);
    // Back-to-back jumps: second lands in the flush slot
    cyc(8'hE7, 0, 0);
    cyc(8'hE9, 0, 0);
    cyc(8'h33, 0, 0);
    cyc(8'hFA, 0, 0);
    // Reset arriving during a flush cycle
    cyc(8'hE1, 0, 0);
    cyc(8'h21, 0, 0);
    cyc(8'h21, 0, 1);
    cyc(8'h56, 0, 0);
    cyc(8'h00, 0, 0);
    // Random instruction stream, jumps favoured to exercise flushing
    for (int i = 0; i < 400; i++) begin
      int ins;
      if ($urandom_range(0, 3) == 0) ins = $urandom_range(224, 255);
      else                           ins = $urandom_range(0, 255);
      cyc(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_instruction_decoder
`default_nettype wire

// File: doc/instruction_decoder.md
# instruction_decoder

Fetch/decode stage between synchronous program memory and the datapath. Registers the fetched 8-bit instruction into an instruction register (IR), decodes it into datapath load enables, source select and ALU controls, and drives the jump controls (`jmp`, `jmp_nz`, `jmp_addr`) consumed by the program sequencer. Owns the single-cycle branch flush that squashes the wrong-path instruction fetched behind a taken jump.

## Interface
Parameters:
- `NOP_INSTR`, 8'h80, value loaded into IR on reset (move x0←x0 = NOP)

Ports:
- `clk`  in  1  system clock, rising edge
- `sync_reset`  in  1  synchronous, active-high reset
- `pm_data`  in  8  instruction from synchronous program memory, aligned with current `pc`
- `dont_jmp`  in  1  from computational unit; 1 = conditional jump not taken
- `jmp`  out  1  unconditional jump
- `jmp_nz`  out  1  conditional jump request
- `jmp_addr`  out  4  jump target page (target = {jmp_addr, 4'h0})
- `reg_en`  out  8  one-hot destination load enable: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm
- `src_sel`  out  4  source: 0–7 register codes as above, 8 = immediate
- `imm`  out  4  immediate data, IR[3:0]
- `alu_en`  out  1  ALU result register load
- `alu_x_sel`, `alu_y_sel`  out  1 each  ALU operand selects
- `alu_func`  out  3  ALU function code
- `from_ID`  out  8  debug: current IR contents

## Operation
- Every rising edge: IR ← `pm_data`; `flush` ← taken jump decoded this cycle.
- Decode is combinational from IR, gated by `flush`:
  - `0ddd_iiii` load immediate: `reg_en[ddd]`=1, `src_sel`=8, `imm`=iiii.
  - `10dd_dsss` move: `reg_en[ddd]`=1, `src_sel`={0,sss}; if ddd==sss, all enables 0 (NOP).
  - `110x_yfff` ALU: `alu_en`=1, `alu_x_sel`=IR[4], `alu_y_sel`=IR[3], `alu_func`=IR[2:0]; `reg_en`=0.
  - `1110_aaaa` jump: `jmp`=1, `jmp_addr`=aaaa.
  - `1111_aaaa` conditional: `jmp_nz`=1, `jmp_addr`=aaaa.
- Taken = `jmp` | (`jmp_nz` & ~`dont_jmp`), evaluated on ungated decode.
- While `flush`=1: all enables, `jmp`, `jmp_nz`, `alu_en` forced 0; `src_sel`, `imm`, `jmp_addr`, ALU selects don't-care (drive 0). IR still loads normally.
- Not-taken `jmp_nz`: no flush; next instruction executes.
- Back-to-back jumps: jump in flush slot is squashed; jump at target executes normally.

## Timing
- Reset (sync, held ≥1 edge): IR ← `NOP_INSTR`, `flush` ← 0. All control outputs 0, `from_ID`=8'h80, `src_sel`=0.
- First cycle after reset release: pc=0, `pm_data`=instr(0), IR=NOP; instr(0) executes (controls asserted) one cycle later.
- Pipeline latency: instruction at address P drives controls in the cycle where pc=P+1.
- Taken jump at P: cycle k controls asserted → sequencer fetches target; cycle k+1 IR=instr(P+1), flushed; cycle k+2 IR=instr(target), executes. Exactly one bubble.
- `dont_jmp` sampled combinationally in the decode cycle; must be stable before edge.
- Reset during flush cycle: reset wins; `flush` cleared, IR=NOP.
- No combinational path from `pm_data` to any output.

## Structure
- Shared package `cpu_pkg`: opcode prefix constants, destination codes (X0…DM), `SRC_IMM`=4'd8, `NOP_INSTR`, ALU function codes.
- Single module; decode logic is one combinational always block plus two registers (IR, `flush`). No sub-module.

## Test plan
- Reset: hold `sync_reset` 2 cycles with `pm_data`=8'hE5 → all controls 0, `from_ID`=8'h80, no jump.
- Load immediate: `pm_data`=8'h37 → next cycle `reg_en`=8'b0000_1000, `src_sel`=8, `imm`=7.
- Move/NOP: 8'h8B (dst 1, src 3) → `reg_en`=8'b0000_0010, `src_sel`=3; 8'h9B (dst 3, src 3) → `reg_en`=0.
- Unconditional jump: 8'hE5 → `jmp`=1, `jmp_addr`=5 for one cycle; following instruction (e.g. 8'h21) fully squashed; instruction after that executes.
- Conditional: 8'hF3 with `dont_jmp`=0 → `jmp_nz`=1, flush next cycle; with `dont_jmp`=1 → `jmp_nz`=1, no flush, next 8'h21 loads y0.
- ALU: 8'hD5 → `alu_en`=1, `alu_x_sel`=1, `alu_y_sel`=0, `alu_func`=3'b101, `reg_en`=0.
